// File: rtl/stage_mm.sv
// stage_mm: memory-access pipeline stage.
// Issues loads and stores to the data memory over a req/ack handshake. Holds the
// pipeline until the access completes, then aligns and extends the load data.
// Non-memory slots pass straight through in a single cycle.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   en, flush                  global pipeline enable, incoming slot is a bubble
//   reg_wr, reg_addr_rd        destination write enable and register index
//   alu_res                    ALU result or effective byte address
//   mem_rd, mem_wr, mem_func3  load/store request and access size/sign
//   store_data                 store value (forwarded rs2)
//   stall                      freeze upstream stages
//   dmem_req/we/addr/be/wdata  registered data-memory request bundle
//   dmem_ack, dmem_rdata       access done, raw read word (same cycle)
//   out_reg_wr/addr_rd/data    write-back and MM forwarding results
//   out_misaligned, out_flush  slot status flags
module stage_mm #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic              reg_wr,
  input  logic [4:0]        reg_addr_rd,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [2:0]        mem_func3,
  input  logic [DATA_W-1:0] store_data,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              out_reg_wr,
  output logic [4:0]        out_reg_addr_rd,
  output logic [DATA_W-1:0] out_reg_data,
  output logic              out_misaligned,
  output logic              out_flush
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t              r_state;
  state_t              w_stateNext;

  logic                r_req;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_be;
  logic [DATA_W-1:0]   r_wdata;
  logic [2:0]          r_func3;
  logic [1:0]          r_off;
  logic [4:0]          r_rd;
  logic                r_regWr;
  logic                r_isLoad;

  logic                r_outWr;
  logic [4:0]          r_outRd;
  logic [DATA_W-1:0]   r_outData;
  logic                r_outMis;
  logic                r_outFlush;

  logic [1:0]          w_off;
  logic                w_isMem;
  logic                w_aligned;
  logic                w_access;
  logic [3:0]          w_be;
  logic [DATA_W-1:0]   w_wdata;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [DATA_W-1:0]   w_loadVal;

  assign w_off    = alu_res[1:0];
  assign w_isMem  = mem_rd | mem_wr;
  assign w_access = en & ~flush & w_isMem & w_aligned;

  // Alignment, byte enables and lane-replicated store data for the incoming slot.
  // func3[1:0] encodes the size; bit 2 only selects zero extension on loads.
  always_comb begin
    w_aligned = 1'b1;
    w_be      = 4'b1111;
    w_wdata   = store_data;
    case (mem_func3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {(DATA_W/8){store_data[7:0]}};
      end
      2'b01: begin
        w_aligned = ~w_off[0];
        w_be      = 4'b0011 << w_off;
        w_wdata   = {(DATA_W/16){store_data[15:0]}};
      end
      default: begin
        w_aligned = (w_off == 2'b00);
      end
    endcase
  end

  // Lane selection and extension of the returned word, using the size and
  // offset latched when the request was issued.
  always_comb begin
    w_byte    = dmem_rdata[8*r_off +: 8];
    w_half    = dmem_rdata[16*r_off[1] +: 16];
    w_loadVal = dmem_rdata;
    case (r_func3)
      3'b000:  w_loadVal = {{(DATA_W-8){w_byte[7]}}, w_byte};
      3'b001:  w_loadVal = {{(DATA_W-16){w_half[15]}}, w_half};
      3'b100:  w_loadVal = {{(DATA_W-8){1'b0}}, w_byte};
      3'b101:  w_loadVal = {{(DATA_W-16){1'b0}}, w_half};
      default: w_loadVal = dmem_rdata;
    endcase
  end

  // Handshake FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  // Next state and stall. Stall drops in the ack cycle so upstream advances at
  // the same edge that captures the load result.
  always_comb begin
    w_stateNext = r_state;
    stall       = 1'b0;
    case (r_state)
      IDLE: begin
        stall = w_access;
        if (w_access) w_stateNext = REQ;
      end
      REQ: begin
        stall = ~dmem_ack;
        if (dmem_ack) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Request bundle and result registers. A pending access ignores en so that it
  // always completes; in IDLE an enabled non-access slot updates the results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= 4'b0000;
      r_wdata    <= '0;
      r_func3    <= 3'b000;
      r_off      <= 2'b00;
      r_rd       <= 5'd0;
      r_regWr    <= 1'b0;
      r_isLoad   <= 1'b0;
      r_outWr    <= 1'b0;
      r_outRd    <= 5'd0;
      r_outData  <= '0;
      r_outMis   <= 1'b0;
      r_outFlush <= 1'b1;
    end else if (r_state == REQ) begin
      if (dmem_ack) begin
        r_req      <= 1'b0;
        r_outWr    <= r_isLoad & r_regWr;
        r_outRd    <= r_rd;
        r_outMis   <= 1'b0;
        r_outFlush <= 1'b0;
        if (r_isLoad) r_outData <= w_loadVal;
      end
    end else if (w_access) begin
      r_req    <= 1'b1;
      r_we     <= mem_wr;
      r_addr   <= {alu_res[ADDR_W-1:2], 2'b00};
      r_be     <= w_be;
      r_wdata  <= w_wdata;
      r_func3  <= mem_func3;
      r_off    <= w_off;
      r_rd     <= reg_addr_rd;
      r_regWr  <= reg_wr;
      r_isLoad <= mem_rd;
    end else if (en) begin
      r_outData <= alu_res;
      r_outRd   <= reg_addr_rd;
      if (w_isMem && !flush) begin
        r_outWr    <= 1'b0;
        r_outMis   <= 1'b1;
        r_outFlush <= 1'b0;
      end else begin
        r_outWr    <= reg_wr & ~flush;
        r_outMis   <= 1'b0;
        r_outFlush <= flush;
      end
    end
  end

  assign dmem_req        = r_req;
  assign dmem_we         = r_we;
  assign dmem_addr       = r_addr;
  assign dmem_be         = r_be;
  assign dmem_wdata      = r_wdata;
  assign out_reg_wr      = r_outWr;
  assign out_reg_addr_rd = r_outRd;
  assign out_reg_data    = r_outData;
  assign out_misaligned  = r_outMis;
  assign out_flush       = r_outFlush;

endmodule

// File: tb/tb_stage_mm.sv
// tb_stage_mm: self-checking bench for stage_mm.
// Directed scenarios followed by randomized slots, all checked against a
// reference model built from plain arithmetic on sizes and offsets. The bench
// plays the data memory and drives dmem_ack with a chosen latency.
module tb_stage_mm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic        reg_wr = 1'b0;
  logic [4:0]  reg_addr_rd = 5'd0;
  logic [31:0] alu_res = 32'd0;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [2:0]  mem_func3 = 3'd0;
  logic [31:0] store_data = 32'd0;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        out_reg_wr;
  logic [4:0]  out_reg_addr_rd;
  logic [31:0] out_reg_data;
  logic        out_misaligned;
  logic        out_flush;

  int errors = 0;
  int checks = 0;

  // Model of the result registers; dataKnown is cleared after slots whose
  // write-back data/register are left undefined (stores, misaligned accesses).
  logic        expWr = 1'b0;
  logic [4:0]  expRd = 5'd0;
  logic [31:0] expData = 32'd0;
  logic        expMis = 1'b0;
  logic        expFlush = 1'b1;
  logic        dataKnown = 1'b1;

  // Observations captured during the most recent transaction.
  int          stallCount;
  logic [31:0] capAddr;
  logic [3:0]  capBe;
  logic [31:0] capWdata;
  logic        capWe;
  logic        capReq;

  logic [2:0]  f3Tab [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  stage_mm #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .reg_wr(reg_wr),
    .reg_addr_rd(reg_addr_rd), .alu_res(alu_res), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_func3(mem_func3), .store_data(store_data),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .out_reg_wr(out_reg_wr),
    .out_reg_addr_rd(out_reg_addr_rd), .out_reg_data(out_reg_data),
    .out_misaligned(out_misaligned), .out_flush(out_flush)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic stepClock;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic e, input logic fl, input logic rw, input logic [4:0] rd,
                               input logic [31:0] alu, input logic mrd, input logic mwr,
                               input logic [2:0] f3, input logic [31:0] sd);
    en = e; flush = fl; reg_wr = rw; reg_addr_rd = rd; alu_res = alu;
    mem_rd = mrd; mem_wr = mwr; mem_func3 = f3; store_data = sd;
  endtask

  function automatic int refSize(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] refBe(input logic [2:0] f3, input logic [31:0] addr);
    int m;
    m = ((1 << refSize(f3)) - 1) << (addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] refWdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] r;
    int n;
    n = refSize(f3);
    r = 32'd0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] w);
    int unsigned idx, b, h;
    idx = addr % 4;
    b = (w >> (8 * idx)) & 32'hFF;
    h = (w >> (16 * (idx / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic checkResults(input string tag);
    checkOutput({tag, "_out_reg_wr"}, {31'd0, out_reg_wr}, {31'd0, expWr});
    checkOutput({tag, "_out_flush"}, {31'd0, out_flush}, {31'd0, expFlush});
    checkOutput({tag, "_out_misaligned"}, {31'd0, out_misaligned}, {31'd0, expMis});
    if (dataKnown) begin
      checkOutput({tag, "_out_reg_data"}, out_reg_data, expData);
      checkOutput({tag, "_out_reg_addr_rd"}, {27'd0, out_reg_addr_rd}, {27'd0, expRd});
    end
  endtask

  // One pipeline slot: present it, act as memory with the given ack latency,
  // and check stall, the request bundle and the results against the model.
  task automatic runTxn(input string tag, input logic e, input logic fl, input logic rw,
                        input logic [4:0] rd, input logic [31:0] alu, input logic mrd,
                        input logic mwr, input logic [2:0] f3, input logic [31:0] sd,
                        input int lat, input logic [31:0] rdata);
    logic isMem, aligned, access;
    isMem   = mrd | mwr;
    aligned = (alu % refSize(f3)) == 0;
    access  = e && !fl && isMem && aligned;
    stallCount = 0;
    capReq = 1'b0;
    applyStimulus(e, fl, rw, rd, alu, mrd, mwr, f3, sd);
    #1;
    if (access) begin
      checkOutput({tag, "_stall_issue"}, {31'd0, stall}, 32'd1);
      stallCount += int'(stall);
      stepClock();
      capReq = dmem_req; capAddr = dmem_addr; capBe = dmem_be; capWdata = dmem_wdata; capWe = dmem_we;
      checkOutput({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
      checkOutput({tag, "_we"}, {31'd0, dmem_we}, {31'd0, mwr});
      checkOutput({tag, "_addr"}, dmem_addr, alu & 32'hFFFFFFFC);
      checkOutput({tag, "_be"}, {28'd0, dmem_be}, {28'd0, refBe(f3, alu)});
      if (mwr) checkOutput({tag, "_wdata"}, dmem_wdata, refWdata(f3, sd));
      checkResults({tag, "_hold"});
      for (int c = 1; c < lat; c++) begin
        checkOutput({tag, "_stall_wait"}, {31'd0, stall}, 32'd1);
        stallCount += int'(stall);
        stepClock();
        checkOutput({tag, "_req_wait"}, {31'd0, dmem_req}, 32'd1);
        checkResults({tag, "_hold"});
      end
      dmem_ack = 1'b1;
      dmem_rdata = rdata;
      #1;
      checkOutput({tag, "_stall_ack"}, {31'd0, stall}, 32'd0);
      stepClock();
      dmem_ack = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0);
      checkOutput({tag, "_req_done"}, {31'd0, dmem_req}, 32'd0);
      expFlush = 1'b0;
      expMis = 1'b0;
      if (mrd) begin
        expWr = rw; expRd = rd; expData = refLoad(f3, alu, rdata); dataKnown = 1'b1;
      end else begin
        expWr = 1'b0; dataKnown = 1'b0;
      end
      checkResults({tag, "_done"});
    end else begin
      checkOutput({tag, "_stall"}, {31'd0, stall}, 32'd0);
      stepClock();
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0);
      checkOutput({tag, "_noreq"}, {31'd0, dmem_req}, 32'd0);
      if (e) begin
        if (isMem && !fl) begin
          expWr = 1'b0; expFlush = 1'b0; expMis = 1'b1; dataKnown = 1'b0;
        end else begin
          expWr = rw & !fl; expRd = rd; expData = alu; expFlush = fl; expMis = 1'b0; dataKnown = 1'b1;
        end
      end
      checkResults(tag);
    end
  endtask

  initial begin
    logic e, fl, rw, mrd, mwr;
    logic [2:0] f3;
    logic [31:0] alu;
    int op;

    // Reset values.
    rst_n = 1'b0;
    repeat (2) stepClock();
    checkOutput("rst_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("rst_we", {31'd0, dmem_we}, 32'd0);
    checkOutput("rst_be", {28'd0, dmem_be}, 32'd0);
    checkResults("rst");
    rst_n = 1'b1;

    // Reset in the middle of a pending load, then a stray ack.
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd9, 32'h100, 1'b1, 1'b0, 3'd2, 32'd0);
    stepClock();
    checkOutput("t1_req_pending", {31'd0, dmem_req}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0);
    rst_n = 1'b0;
    repeat (2) stepClock();
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h12345678;
    stepClock();
    dmem_ack = 1'b0;
    checkOutput("t1_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("t1_stall", {31'd0, stall}, 32'd0);
    checkResults("t1");

    // LW with three wait cycles.
    runTxn("t2", 1'b1, 1'b0, 1'b1, 5'd5, 32'h100, 1'b1, 1'b0, 3'd2, 32'd0, 4, 32'hDEADBEEF);
    checkOutput("t2_stall_cycles", stallCount, 32'd4);
    checkOutput("t2_be_lit", {28'd0, capBe}, 32'hF);
    checkOutput("t2_data_lit", out_reg_data, 32'hDEADBEEF);
    checkOutput("t2_rd_lit", {27'd0, out_reg_addr_rd}, 32'd5);

    // Signed and unsigned byte loads from the top lane.
    runTxn("t3_lb", 1'b1, 1'b0, 1'b1, 5'd6, 32'h203, 1'b1, 1'b0, 3'd0, 32'd0, 1, 32'h80FF0000);
    checkOutput("t3_lb_lit", out_reg_data, 32'hFFFFFF80);
    runTxn("t3_lbu", 1'b1, 1'b0, 1'b1, 5'd6, 32'h203, 1'b1, 1'b0, 3'd4, 32'd0, 2, 32'h80FF0000);
    checkOutput("t3_lbu_lit", out_reg_data, 32'h00000080);

    // Upper-half store.
    runTxn("t4", 1'b1, 1'b0, 1'b0, 5'd0, 32'h302, 1'b0, 1'b1, 3'd1, 32'h1234ABCD, 1, 32'd0);
    checkOutput("t4_addr_lit", capAddr, 32'h300);
    checkOutput("t4_be_lit", {28'd0, capBe}, 32'hC);
    checkOutput("t4_wdata_lit", capWdata, 32'hABCDABCD);
    checkOutput("t4_we_lit", {31'd0, capWe}, 32'd1);

    // Misaligned word load.
    runTxn("t5", 1'b1, 1'b0, 1'b1, 5'd4, 32'h101, 1'b1, 1'b0, 3'd2, 32'd0, 1, 32'd0);
    checkOutput("t5_mis_lit", {31'd0, out_misaligned}, 32'd1);

    // ALU write-back followed by a flushed load.
    runTxn("t6_add", 1'b1, 1'b0, 1'b1, 5'd7, 32'h42, 1'b0, 1'b0, 3'd0, 32'd0, 1, 32'd0);
    checkOutput("t6_data_lit", out_reg_data, 32'h42);
    checkOutput("t6_wr_lit", {31'd0, out_reg_wr}, 32'd1);
    runTxn("t6_flush", 1'b1, 1'b1, 1'b1, 5'd3, 32'h100, 1'b1, 1'b0, 3'd2, 32'd0, 1, 32'd0);
    checkOutput("t6_flush_lit", {31'd0, out_flush}, 32'd1);

    // Randomized slots.
    for (int k = 0; k < 60; k++) begin
      op  = $urandom_range(0, 2);
      e   = ($urandom_range(0, 9) != 0);
      fl  = ($urandom_range(0, 7) == 0);
      rw  = $urandom_range(0, 1);
      alu = $urandom;
      mrd = (op == 1);
      mwr = (op == 2);
      f3  = (op == 2) ? f3Tab[$urandom_range(0, 2)] : f3Tab[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) != 0) alu[1:0] = (refSize(f3) == 4) ? 2'd0 : ((refSize(f3) == 2) ? {alu[1], 1'b0} : alu[1:0]);
      runTxn("rnd", e, fl, rw, 5'($urandom), alu, mrd, mwr, f3, $urandom,
             $urandom_range(1, 3), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
